serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_adder_digit.sv | 29 ++
 rtl/serial_adder.sv | 144 ++++++++++++++
 tb/tb_serial_adder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encoding and the slice-counter width helper.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width for N slices; a single-slice build still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_adder_digit.sv
// Combinational DIGIT-bit ripple adder assembled from single-bit
// full-adder cells; one slice of the serial datapath.
module adder_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             cin_i,
   output logic [DIGIT-1:0] sum_o,
   output logic             cout_o
);

   logic [DIGIT:0] carry;

   assign carry[0] = cin_i;

   genvar gi;
   generate
      for (gi = 0; gi < DIGIT; gi++) begin : g_fa
         logic p;
         assign p             = a_i[gi] ^ b_i[gi];
         assign sum_o[gi]     = p ^ carry[gi];
         assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & p);
      end
   endgenerate

   assign cout_o = carry[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock with the
// carry held in a register, wrapped in a start/busy/done handshake.
import serial_adder_pkg::*;

module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0] a_dig, b_dig, dig_sum;
   logic             dig_cout;
   logic [WIDTH-1:0] work_merged;

   // Select the operand slice addressed by the slice counter.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt_q == CW'(i)) begin
            a_dig = a_q[i*DIGIT +: DIGIT];
            b_dig = b_q[i*DIGIT +: DIGIT];
         end
      end
   end

   adder_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a_i    (a_dig),
      .b_i    (b_dig),
      .cin_i  (carry_q),
      .sum_o  (dig_sum),
      .cout_o (dig_cout)
   );

   // Working result with the current slice written in place.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_merge
         assign work_merged[gi*DIGIT +: DIGIT] =
            (cnt_q == CW'(gi)) ? dig_sum : work_q[gi*DIGIT +: DIGIT];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               work_d  = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            work_d  = work_merged;
            carry_d = dig_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Results become visible only here, never slice by slice.
               cnt_d   = '0;
               sum_d   = work_merged;
               cout_d  = dig_cout;
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (work_merged[WIDTH-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three builds (DIGIT = 1, 4, 8) share stimulus and
// are checked against an arithmetic reference model.
module tb_serial_adder;

   localparam int NS [3] = '{8, 2, 1};

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic       cin;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       sub;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;

   logic       busy_w [3];
   logic       done_w [3];
   logic [7:0] sum_w  [3];
   logic       cout_w [3];
   logic       ovf_w  [3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));
   serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic vec_t model(input logic [7:0] va, input logic [7:0] vb,
                                  input logic vsub, input logic vcin);
      vec_t       r;
      logic [8:0] full;
      int         sa, sb, sr;
      sa = int'($signed(va));
      sb = int'($signed(vb));
      if (vsub) begin
         full = {1'b0, va} + {1'b0, ~vb} + 9'd1;
         sr   = sa - sb;
      end else begin
         full = {1'b0, va} + {1'b0, vb} + {8'd0, vcin};
         sr   = sa + sb + int'(vcin);
      end
      r.a = va; r.b = vb; r.sub = vsub; r.cin = vcin;
      r.s  = full[7:0];
      r.co = full[8];
      r.ov = (sr > 127) || (sr < -128);
      return r;
   endfunction

   task automatic check(input string nm, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
   endtask

   task automatic check_idle(input string tag);
      for (int k = 0; k < 3; k++) begin
         check({tag, " busy"}, k, 32'(busy_w[k]), 32'd0);
         check({tag, " done"}, k, 32'(done_w[k]), 32'd0);
         check({tag, " sum"},  k, 32'(sum_w[k]),  32'd0);
         check({tag, " cout"}, k, 32'(cout_w[k]), 32'd0);
         check({tag, " ovf"},  k, 32'(ovf_w[k]),  32'd0);
      end
   endtask

   // One start pulse, garbage on the operand inputs while running, then
   // per-build checks of latency, handshake, stability and result.
   task automatic run_and_check(input vec_t v, input string tag);
      int         busy_cnt [3];
      int         done_cnt [3];
      int         done_cyc [3];
      int         chg      [3];
      logic [7:0] prev     [3];
      logic [7:0] rs       [3];
      logic       rc       [3];
      logic       ro       [3];
      @(negedge clk);
      a = v.a; b = v.b; sub = v.sub; cin = v.cin; start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         busy_cnt[k] = 0; done_cnt[k] = 0; done_cyc[k] = -1; chg[k] = 0;
         prev[k] = sum_w[k]; rs[k] = 8'hxx; rc[k] = 1'bx; ro[k] = 1'bx;
      end
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (busy_w[k]) begin
               busy_cnt[k]++;
               if (sum_w[k] !== prev[k]) chg[k]++;
            end
            if (done_w[k]) begin
               done_cnt[k]++;
               done_cyc[k] = c;
               rs[k] = sum_w[k]; rc[k] = cout_w[k]; ro[k] = ovf_w[k];
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         $display("op %s dut%0d: a=%02h b=%02h sub=%0d cin=%0d -> sum=%02h cout=%0d ovf=%0d",
                  tag, k, v.a, v.b, v.sub, v.cin, rs[k], rc[k], ro[k]);
         check({tag, " busy cycles"}, k, 32'(busy_cnt[k]), 32'(NS[k]));
         check({tag, " done count"},  k, 32'(done_cnt[k]), 32'd1);
         check({tag, " done cycle"},  k, 32'(done_cyc[k]), 32'(NS[k]));
         check({tag, " sum stable"},  k, 32'(chg[k]), 32'd0);
         check({tag, " sum"},  k, 32'(rs[k]), 32'(v.s));
         check({tag, " cout"}, k, 32'(rc[k]), 32'(v.co));
         check({tag, " ovf"},  k, 32'(ro[k]), 32'(v.ov));
         check({tag, " sum hold"}, k, 32'(sum_w[k]), 32'(v.s));
      end
   endtask

   task automatic drain();
      start = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      vec_t       tbl [6];
      vec_t       v, va, vb;
      int         ndone, consec, d2cyc, dcnt, dcyc;
      bit         busy_after;
      logic       pd;
      logic [7:0] r1s, r2s;
      logic       r1c, r1o, r2c, r2o;

      tbl[0] = '{a:8'h0F, b:8'h01, sub:1'b0, cin:1'b0, s:8'h10, co:1'b0, ov:1'b0};
      tbl[1] = '{a:8'hFF, b:8'h01, sub:1'b0, cin:1'b0, s:8'h00, co:1'b1, ov:1'b0};
      tbl[2] = '{a:8'h7F, b:8'h01, sub:1'b0, cin:1'b0, s:8'h80, co:1'b0, ov:1'b1};
      tbl[3] = '{a:8'h05, b:8'h07, sub:1'b1, cin:1'b1, s:8'hFE, co:1'b0, ov:1'b0};
      tbl[4] = '{a:8'h80, b:8'h01, sub:1'b1, cin:1'b0, s:8'h7F, co:1'b1, ov:1'b1};
      tbl[5] = '{a:8'hAB, b:8'h55, sub:1'b0, cin:1'b1, s:8'h01, co:1'b1, ov:1'b0};

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_and_check(tbl[i], $sformatf("table%0d", i));

      for (int i = 0; i < 20; i++) begin
         v = model(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
         run_and_check(v, $sformatf("rand%0d", i));
      end

      // start pulsed mid-RUN must not disturb the DIGIT=1 operation
      @(negedge clk);
      a = 8'h0F; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcnt = 0; dcyc = -1; r1s = 8'hxx; r1c = 1'bx; r1o = 1'bx;
      for (int c = 0; c < 14; c++) begin
         if (c > 0) @(negedge clk);
         if (done_w[0]) begin
            dcnt++; dcyc = c; r1s = sum_w[0]; r1c = cout_w[0]; r1o = ovf_w[0];
         end
         if (c == 2) begin
            start = 1'b1; a = 8'h55; b = 8'h33; sub = 1'b1; cin = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      $display("ignore-start: sum=%02h cout=%0d ovf=%0d done_cycle=%0d", r1s, r1c, r1o, dcyc);
      check("ignstart done count", 0, 32'(dcnt), 32'd1);
      check("ignstart done cycle", 0, 32'(dcyc), 32'd8);
      check("ignstart sum",  0, 32'(r1s), 32'h10);
      check("ignstart cout", 0, 32'(r1c), 32'd0);
      check("ignstart ovf",  0, 32'(r1o), 32'd0);
      drain();

      // start held through DONE: second op begins back-to-back
      va = model(8'h7F, 8'h01, 1'b0, 1'b0);
      vb = model(8'h80, 8'h01, 1'b1, 1'b0);
      @(negedge clk);
      a = va.a; b = va.b; sub = va.sub; cin = va.cin; start = 1'b1;
      @(negedge clk);
      a = vb.a; b = vb.b; sub = vb.sub; cin = vb.cin;
      ndone = 0; consec = 0; d2cyc = -1; busy_after = 1'b0; pd = 1'b0;
      r1s = 8'hxx; r1c = 1'bx; r1o = 1'bx; r2s = 8'hxx; r2c = 1'bx; r2o = 1'bx;
      for (int c = 0; c < 40; c++) begin
         if (pd && busy_w[0]) busy_after = 1'b1;
         if (done_w[0]) begin
            if (pd) consec++;
            ndone++;
            if (ndone == 1) begin
               r1s = sum_w[0]; r1c = cout_w[0]; r1o = ovf_w[0];
            end else begin
               r2s = sum_w[0]; r2c = cout_w[0]; r2o = ovf_w[0]; d2cyc = c;
               start = 1'b0;
            end
         end
         pd = done_w[0];
         if (ndone >= 2) break;
         @(negedge clk);
      end
      $display("back-to-back: first=%02h/%0d/%0d second=%02h/%0d/%0d second_done=%0d",
               r1s, r1c, r1o, r2s, r2c, r2o, d2cyc);
      check("b2b done count",  0, 32'(ndone), 32'd2);
      check("b2b consecutive done", 0, 32'(consec), 32'd0);
      check("b2b busy after done",  0, 32'(busy_after), 32'd1);
      check("b2b second done cycle", 0, 32'(d2cyc), 32'd17);
      check("b2b first sum",   0, 32'(r1s), 32'(va.s));
      check("b2b first cout",  0, 32'(r1c), 32'(va.co));
      check("b2b first ovf",   0, 32'(r1o), 32'(va.ov));
      check("b2b second sum",  0, 32'(r2s), 32'(vb.s));
      check("b2b second cout", 0, 32'(r2c), 32'(vb.co));
      check("b2b second ovf",  0, 32'(r2o), 32'(vb.ov));
      drain();

      // reset during RUN cycle 4 abandons the operation
      @(negedge clk);
      a = 8'hFF; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("mid-run reset: busy=%0d done=%0d sum=%02h", busy_w[0], done_w[0], sum_w[0]);
      check_idle("midrun reset");
      dcnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) if (done_w[k]) dcnt++;
      end
      check("no done after reset", 0, 32'(dcnt), 32'd0);
      run_and_check(tbl[0], "after-reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
